// File: rtl/cp0_pkg.sv
// rtl/cp0_pkg.sv - CP0 register numbers, TLB op codes, FSM states and field positions
package cp0_pkg;

  localparam int TLB_NUM = 16;

  localparam logic [4:0] CP0_INDEX    = 5'd0;
  localparam logic [4:0] CP0_ENTRYLO0 = 5'd2;
  localparam logic [4:0] CP0_ENTRYLO1 = 5'd3;
  localparam logic [4:0] CP0_ENTRYHI  = 5'd10;

  typedef enum logic [1:0] {
    OP_TLBP  = 2'b00,
    OP_TLBR  = 2'b01,
    OP_TLBWI = 2'b10,
    OP_NONE  = 2'b11
  } tlb_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PROBE,
    ST_READ,
    ST_WRITE,
    ST_DONE
  } cp0_state_e;

  localparam int EHI_VPN2_LSB = 13;
  localparam int EHI_ASID_W   = 8;

  localparam int ELO_W       = 26;
  localparam int ELO_PFN_LSB = 6;
  localparam int ELO_C_LSB   = 3;
  localparam int ELO_D_BIT   = 2;
  localparam int ELO_V_BIT   = 1;
  localparam int ELO_G_BIT   = 0;

  localparam int IDX_P_BIT = 31;

endpackage

// File: rtl/tlb_cp0_ctrl.sv
// rtl/tlb_cp0_ctrl.sv - CP0 TLB register file and TLBP/TLBR/TLBWI sequencer
module tlb_cp0_ctrl
  import cp0_pkg::*;
#(
  parameter int TLBNUM = TLB_NUM,
  localparam int IDXW = $clog2(TLBNUM)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            op_valid,
  input  logic [1:0]      op,
  output logic            op_ready,
  output logic            op_done,
  input  logic            mtc0_we,
  input  logic [4:0]      mtc0_addr,
  input  logic [31:0]     mtc0_wdata,
  input  logic [4:0]      mfc0_addr,
  output logic [31:0]     mfc0_rdata,
  input  logic            exc_we,
  input  logic [18:0]     exc_vpn2,
  output logic [18:0]     s1_vpn2,
  output logic            s1_odd_page,
  output logic [7:0]      s1_asid,
  input  logic            s1_found,
  input  logic [IDXW-1:0] s1_index,
  output logic [IDXW-1:0] r_index,
  input  logic [18:0]     r_vpn2,
  input  logic [7:0]      r_asid,
  input  logic            r_g,
  input  logic [19:0]     r_pfn0,
  input  logic [2:0]      r_c0,
  input  logic            r_d0,
  input  logic            r_v0,
  input  logic [19:0]     r_pfn1,
  input  logic [2:0]      r_c1,
  input  logic            r_d1,
  input  logic            r_v1,
  output logic            we,
  output logic [IDXW-1:0] w_index,
  output logic [18:0]     w_vpn2,
  output logic [7:0]      w_asid,
  output logic            w_g,
  output logic [19:0]     w_pfn0,
  output logic [2:0]      w_c0,
  output logic            w_d0,
  output logic            w_v0,
  output logic [19:0]     w_pfn1,
  output logic [2:0]      w_c1,
  output logic            w_d1,
  output logic            w_v1
);

  cp0_state_e       state;
  logic [18:0]      ehi_vpn2;
  logic [7:0]       ehi_asid;
  logic [ELO_W-1:0] entrylo0;
  logic [ELO_W-1:0] entrylo1;
  logic             idx_p;
  logic [IDXW-1:0]  idx;

  assign op_ready = (state == ST_IDLE);
  assign op_done  = (state == ST_DONE);
  assign we       = (state == ST_WRITE);

  assign s1_vpn2     = ehi_vpn2;
  assign s1_asid     = ehi_asid;
  assign s1_odd_page = 1'b0;
  assign r_index     = idx;

  assign w_index = idx;
  assign w_vpn2  = ehi_vpn2;
  assign w_asid  = ehi_asid;
  assign w_g     = entrylo0[ELO_G_BIT] & entrylo1[ELO_G_BIT];
  assign w_pfn0  = entrylo0[ELO_W-1:ELO_PFN_LSB];
  assign w_c0    = entrylo0[ELO_PFN_LSB-1:ELO_C_LSB];
  assign w_d0    = entrylo0[ELO_D_BIT];
  assign w_v0    = entrylo0[ELO_V_BIT];
  assign w_pfn1  = entrylo1[ELO_W-1:ELO_PFN_LSB];
  assign w_c1    = entrylo1[ELO_PFN_LSB-1:ELO_C_LSB];
  assign w_d1    = entrylo1[ELO_D_BIT];
  assign w_v1    = entrylo1[ELO_V_BIT];

  always_comb begin
    mfc0_rdata = '0;
    case (mfc0_addr)
      CP0_INDEX: begin
        mfc0_rdata[IDX_P_BIT]  = idx_p;
        mfc0_rdata[IDXW-1:0]   = idx;
      end
      CP0_ENTRYLO0: mfc0_rdata[ELO_W-1:0] = entrylo0;
      CP0_ENTRYLO1: mfc0_rdata[ELO_W-1:0] = entrylo1;
      CP0_ENTRYHI:  mfc0_rdata = {ehi_vpn2, 5'b0, ehi_asid};
      default:      mfc0_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      ehi_vpn2 <= '0;
      ehi_asid <= '0;
      entrylo0 <= '0;
      entrylo1 <= '0;
      idx_p    <= 1'b0;
      idx      <= '0;
    end else begin
      // Later assignments override earlier ones: mtc0, then exc, then FSM capture.
      if (mtc0_we) begin
        case (mtc0_addr)
          CP0_INDEX:    idx      <= mtc0_wdata[IDXW-1:0];
          CP0_ENTRYLO0: entrylo0 <= mtc0_wdata[ELO_W-1:0];
          CP0_ENTRYLO1: entrylo1 <= mtc0_wdata[ELO_W-1:0];
          CP0_ENTRYHI: begin
            ehi_vpn2 <= mtc0_wdata[31:EHI_VPN2_LSB];
            ehi_asid <= mtc0_wdata[EHI_ASID_W-1:0];
          end
          default: ;
        endcase
      end
      if (exc_we) ehi_vpn2 <= exc_vpn2;

      case (state)
        ST_IDLE: begin
          if (op_valid) begin
            case (tlb_op_e'(op))
              OP_TLBP:  state <= ST_PROBE;
              OP_TLBR:  state <= ST_READ;
              OP_TLBWI: state <= ST_WRITE;
              default:  state <= ST_DONE;
            endcase
          end
        end
        ST_PROBE: begin
          // The probe owns Index this cycle, so a miss also holds idx against mtc0.
          idx_p <= ~s1_found;
          idx   <= s1_found ? s1_index : idx;
          state <= ST_DONE;
        end
        ST_READ: begin
          ehi_vpn2 <= r_vpn2;
          ehi_asid <= r_asid;
          entrylo0 <= {r_pfn0, r_c0, r_d0, r_v0, r_g};
          entrylo1 <= {r_pfn1, r_c1, r_d1, r_v1, r_g};
          state    <= ST_DONE;
        end
        ST_WRITE: state <= ST_DONE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/tlb_cp0_ctrl.md
# tlb_cp0_ctrl

CP0-side controller that owns the EntryHi, EntryLo0, EntryLo1 and Index registers and executes TLBP, TLBR and TLBWI against the `tlb` block. It sits directly upstream of `tlb`: it drives search port 1, the read port and the write port. It accepts one TLB instruction at a time from the writeback stage over a valid/ready handshake and reports completion with a one-cycle done pulse.

## Interface
- TLBNUM, 16, number of TLB entries; IDXW = $clog2(TLBNUM)
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- op_valid  in  1  TLB instruction request
- op  in  2  00 TLBP, 01 TLBR, 10 TLBWI, 11 reserved (no-op)
- op_ready  out  1  high only in IDLE
- op_done  out  1  one-cycle completion pulse
- mtc0_we / mtc0_addr / mtc0_wdata  in  1/5/32  CP0 write: reg 0 Index, 2 EntryLo0, 3 EntryLo1, 10 EntryHi
- mfc0_addr  in  5;  mfc0_rdata  out  32  combinational CP0 read, 0 for other addresses
- exc_we  in  1;  exc_vpn2  in  19  TLB-exception update of EntryHi.VPN2
- s1_vpn2/s1_odd_page/s1_asid  out  19/1/8;  s1_found/s1_index  in  1/IDXW
- r_index  out  IDXW;  r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0, r_pfn1, r_c1, r_d1, r_v1  in
- we, w_index, w_vpn2, w_asid, w_g, w_pfn0, w_c0, w_d0, w_v0, w_pfn1, w_c1, w_d1, w_v1  out

## Operation
- Register formats:
  - EntryHi = {VPN2[31:13], 5'b0, ASID[7:0]}
  - EntryLoN = {6'b0, PFN[25:6], C[5:3], D[2], V[1], G[0]}
  - Index = {P[31], 0, idx[IDXW-1:0]}
  - Zero fields are read-only 0. mtc0 to Index writes idx only; P is hardware-only.
- FSM: IDLE, PROBE, READ, WRITE, DONE.
  - IDLE plus accepted op: 00 goes to PROBE, 01 to READ, 10 to WRITE, 11 to DONE.
  - PROBE, READ and WRITE always go to DONE. DONE goes to IDLE.
- PROBE:
  - s1_vpn2 = EntryHi.VPN2, s1_asid = EntryHi.ASID, s1_odd_page = 0.
  - At the end of the cycle, if found: P = 0 and idx = s1_index. If not found: P = 1 and idx is unchanged.
- READ:
  - r_index = Index.idx.
  - At the end of the cycle, EntryHi ← {r_vpn2, r_asid}, EntryLo0 ← {r_pfn0, r_c0, r_d0, r_v0, r_g}, EntryLo1 likewise with the *1 fields and the same r_g.
- WRITE:
  - we = 1 for exactly this cycle, w_index = Index.idx.
  - w_vpn2 and w_asid come from EntryHi; pfn/c/d/v come from EntryLo0 and EntryLo1.
  - w_g = EntryLo0.G & EntryLo1.G.
- we is decoded from state, so it is never high outside WRITE.
- s1_* and r_index are driven continuously from the registers in every state.
- Priority when several sources write the same register in one cycle: FSM capture > exc_we > mtc0_we.
- mtc0 and exc updates are honoured in every state, subject to that priority.

## Timing
- Accept at edge N (op_valid & op_ready). Action cycle N+1. op_done is high during N+2. op_ready is high again at N+3.
- An op_valid held high in DONE is not accepted.
- mtc0 written at edge N is visible to an op whose action cycle is N+1 or later.
- mfc0_rdata reflects register state combinationally, with the same-cycle write not yet applied.
- Reset (asynchronous):
  - Outputs: state = IDLE, op_ready = 1, op_done = 0, we = 0.
  - Registers: EntryHi = 0, EntryLo0 = 0, EntryLo1 = 0, Index = 0 (P = 0).
- Reset in the middle of an op aborts it: no done pulse and no write.

## Structure
- Shared package `cp0_pkg`:
  - CP0 register numbers (INDEX = 0, ENTRYLO0 = 2, ENTRYLO1 = 3, ENTRYHI = 10).
  - TLB op encodings.
  - FSM state enum.
  - EntryHi and EntryLo field-position constants.
- Single module, no sub-module. The FSM and the register file are under 300 lines.

## Test plan
- mtc0 EntryHi = 0x0040_0005 and Index = 3. Mock tlb asserts s1_found with s1_index = 7 for VPN2 0x00200 and ASID 5. Issue TLBP → op_done 2 cycles after accept; Index reads 0x0000_0007.
- TLBP with mock s1_found = 0 and Index = 3 → Index reads 0x8000_0003.
- Index = 5, EntryLo0 = 0x0000_1017, EntryLo1 = 0x0000_2016. Issue TLBWI → we high for exactly one cycle with w_index = 5, w_pfn0 = 0x40, w_c0 = 2, w_d0 = 1, w_v0 = 1, w_g = 0.
- Index = 2, mock read port returns vpn2 = 0x12345, asid = 0x9A, g = 1. Issue TLBR → EntryHi = 0x2468_A09A; both EntryLo registers have G = 1.
- During the READ cycle, drive mtc0 to EntryHi and exc_we together → the TLBR capture wins. In IDLE, drive exc_we and mtc0 together → EntryHi.VPN2 takes exc_vpn2.
- Assert reset during the WRITE cycle → we drops immediately, no op_done pulse, all registers read 0, op_ready = 1.
